// File: rtl/pwls_sweep_pkg.sv
// Shared definitions for the PWL sweep unit: register map, ctrl field
// layout and frame counter sizing.
package pwls_sweep_pkg;

    // Register index within a channel (low two address bits)
    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_AMP    = 2'd1;
    localparam logic [1:0] REG_SWEEP  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // Bit offsets of the period and amp halves of the sweep ctrl word
    localparam int P_OFS = 0;
    localparam int A_OFS = 8;

    // Widest rate field supported; narrower rates are zero-extended
    localparam int RATE_MAX_W = 6;

    // Storage slots addressable by the 4-bit channel field
    localparam int CH_SLOTS = 16;

    typedef struct packed {
        logic [RATE_MAX_W-1:0] prate;
        logic                  pdir;
        logic                  pwrap;
        logic [RATE_MAX_W-1:0] arate;
        logic                  adir;
        logic                  apingpong;
    } sweep_ctrl_t;

    // Frame counter width needed so the slowest rate still has a full mask
    function automatic int frame_cnt_bits(input int rate_bits);
        return (1 << rate_bits) - 2;
    endfunction

endpackage

// File: rtl/pwls_sweep_if.sv
// Register write port and per-cycle channel output bus of the sweep unit.
interface pwls_sweep_if #(
    parameter int PERIOD_BITS = 13,
    parameter int AMP_BITS    = 6,
    parameter int REG_BITS    = 16
);
    logic                   en;
    logic [5:0]             reg_waddr;
    logic [REG_BITS-1:0]    reg_wdata;
    logic                   reg_we;
    logic [3:0]             out_channel;
    logic [PERIOD_BITS-1:0] out_period;
    logic [AMP_BITS-1:0]    out_amp;
    logic                   out_valid;
    logic                   frame_tick;

    modport master (
        output en, reg_waddr, reg_wdata, reg_we,
        input  out_channel, out_period, out_amp, out_valid, frame_tick
    );

    modport slave (
        input  en, reg_waddr, reg_wdata, reg_we,
        output out_channel, out_period, out_amp, out_valid, frame_tick
    );
endinterface

// File: rtl/pwls_sweep_step.sv
// One +/-1 sweep step for a single value. MODE selects wrap (period) or
// ping-pong (amp) behaviour at the range ends; MODE=0 saturates.
module pwls_sweep_step
    import pwls_sweep_pkg::*;
#(
    parameter int W        = 13,
    parameter int FC_W     = 14,
    parameter bit PINGPONG = 1'b0
) (
    input  logic [W-1:0]          value,
    input  logic                  dir,
    input  logic [RATE_MAX_W-1:0] rate,
    input  logic                  mode,
    input  logic [FC_W-1:0]       frame_cnt,
    output logic [W-1:0]          next_value,
    output logic                  next_dir
);

    localparam logic [W-1:0] ONE   = 1;
    localparam logic [W-1:0] MAX_V = '1;

    logic mask_clear;
    logic do_step;

    // Rate r steps when the low r-1 frame counter bits are all zero
    always_comb begin
        mask_clear = 1'b1;
        for (int i = 0; i < FC_W; i++) begin
            if ((i + 1) < int'(rate) && frame_cnt[i]) begin
                mask_clear = 1'b0;
            end
        end
        do_step = (rate != '0) && mask_clear;
    end

    // Apply the step with the selected end-of-range behaviour
    always_comb begin
        next_value = value;
        next_dir   = dir;
        if (do_step) begin
            if (!dir) begin
                if (value == MAX_V) begin
                    if (mode && PINGPONG) begin
                        next_dir = 1'b1;
                    end else if (mode) begin
                        next_value = '0;
                    end
                end else begin
                    next_value = value + ONE;
                end
            end else begin
                if (value == '0) begin
                    if (mode && PINGPONG) begin
                        next_dir = 1'b0;
                    end else if (mode) begin
                        next_value = MAX_V;
                    end
                end else begin
                    next_value = value - ONE;
                end
            end
        end
    end

endmodule

// File: rtl/pwls_sweep_unit.sv
// Time-multiplexed sweep engine: one channel's period/amp is stepped and
// reported per enabled cycle; register writes land at any time.
module pwls_sweep_unit
    import pwls_sweep_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int PERIOD_BITS  = 13,
    parameter int AMP_BITS     = 6,
    parameter int RATE_BITS    = 4,
    parameter int REG_BITS     = 16
) (
    input  logic         clk,
    input  logic         reset,
    pwls_sweep_if.slave  bus
);

    localparam int         FC_RAW  = frame_cnt_bits(RATE_BITS);
    localparam int         FC_W    = (FC_RAW < 1) ? 1 : FC_RAW;
    localparam logic [3:0] LAST_CH = 4'(NUM_CHANNELS - 1);
    localparam logic [4:0] NCH     = 5'(NUM_CHANNELS);
    localparam logic [FC_W-1:0] FC_ONE = 1;

    // Unpack a written ctrl word; bits outside the defined fields drop out
    function automatic sweep_ctrl_t decode_ctrl(input logic [REG_BITS-1:0] d);
        sweep_ctrl_t c;
        c = '0;
        for (int i = 0; i < RATE_BITS; i++) begin
            c.prate[i] = d[P_OFS + i];
            c.arate[i] = d[A_OFS + i];
        end
        c.pdir      = d[P_OFS + RATE_BITS];
        c.pwrap     = d[P_OFS + RATE_BITS + 1];
        c.adir      = d[A_OFS + RATE_BITS];
        c.apingpong = d[A_OFS + RATE_BITS + 1];
        return c;
    endfunction

    logic [PERIOD_BITS-1:0] period_q [CH_SLOTS];
    logic [AMP_BITS-1:0]    amp_q    [CH_SLOTS];
    sweep_ctrl_t            ctrl_q   [CH_SLOTS];
    logic [3:0]             ch_idx;
    logic [FC_W-1:0]        frame_cnt;

    logic [3:0]             out_channel_p1;
    logic [PERIOD_BITS-1:0] out_period_p1;
    logic [AMP_BITS-1:0]    out_amp_p1;
    logic                   vld_p1;
    logic                   frame_tick_p1;

    // Stage 0: current channel state and its swept successor
    logic [PERIOD_BITS-1:0] cur_period_p0;
    logic [AMP_BITS-1:0]    cur_amp_p0;
    sweep_ctrl_t            cur_ctrl_p0;
    logic [PERIOD_BITS-1:0] p_next_p0;
    logic [AMP_BITS-1:0]    a_next_p0;
    logic                   p_next_dir_p0;
    logic                   a_next_dir_p0;
    sweep_ctrl_t            ctrl_next_p0;
    logic                   last_ch_p0;

    assign cur_period_p0 = period_q[ch_idx];
    assign cur_amp_p0    = amp_q[ch_idx];
    assign cur_ctrl_p0   = ctrl_q[ch_idx];
    assign last_ch_p0    = (ch_idx == LAST_CH);

    pwls_sweep_step #(
        .W        (PERIOD_BITS),
        .FC_W     (FC_W),
        .PINGPONG (1'b0)
    ) u_period_step (
        .value      (cur_period_p0),
        .dir        (cur_ctrl_p0.pdir),
        .rate       (cur_ctrl_p0.prate),
        .mode       (cur_ctrl_p0.pwrap),
        .frame_cnt  (frame_cnt),
        .next_value (p_next_p0),
        .next_dir   (p_next_dir_p0)
    );

    pwls_sweep_step #(
        .W        (AMP_BITS),
        .FC_W     (FC_W),
        .PINGPONG (1'b1)
    ) u_amp_step (
        .value      (cur_amp_p0),
        .dir        (cur_ctrl_p0.adir),
        .rate       (cur_ctrl_p0.arate),
        .mode       (cur_ctrl_p0.apingpong),
        .frame_cnt  (frame_cnt),
        .next_value (a_next_p0),
        .next_dir   (a_next_dir_p0)
    );

    // Fold the possibly-toggled direction bits back into the ctrl word
    always_comb begin
        ctrl_next_p0      = cur_ctrl_p0;
        ctrl_next_p0.pdir = p_next_dir_p0;
        ctrl_next_p0.adir = a_next_dir_p0;
    end

    // Register write decode; out-of-range channels and reg 3 are dropped
    logic [3:0]             wr_ch;
    logic [1:0]             wr_reg;
    logic                   wr_ok;
    logic                   wr_period;
    logic                   wr_amp;
    logic                   wr_sweep;
    logic                   wr_hit;
    logic [PERIOD_BITS-1:0] wr_period_val;
    logic [AMP_BITS-1:0]    wr_amp_val;
    logic                   unused_wdata;

    assign wr_ch         = bus.reg_waddr[5:2];
    assign wr_reg        = bus.reg_waddr[1:0];
    assign wr_ok         = bus.reg_we && ({1'b0, wr_ch} < NCH) && (wr_reg != REG_RSVD);
    assign wr_period     = wr_ok && (wr_reg == REG_PERIOD);
    assign wr_amp        = wr_ok && (wr_reg == REG_AMP);
    assign wr_sweep      = wr_ok && (wr_reg == REG_SWEEP);
    assign wr_hit        = (wr_ch == ch_idx);
    assign wr_period_val = bus.reg_wdata[PERIOD_BITS-1:0];
    assign wr_amp_val    = bus.reg_wdata[AMP_BITS-1:0];
    assign unused_wdata  = ^bus.reg_wdata;

    // Stage 1: commit sweep results, advance the schedule, register outputs;
    // a register write issued later in this block overrides the sweep result
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH_SLOTS; i++) begin
                period_q[i] <= '0;
                amp_q[i]    <= '0;
                ctrl_q[i]   <= '0;
            end
            ch_idx         <= '0;
            frame_cnt      <= '0;
            out_channel_p1 <= '0;
            out_period_p1  <= '0;
            out_amp_p1     <= '0;
            vld_p1         <= 1'b0;
            frame_tick_p1  <= 1'b0;
        end else begin
            if (bus.en) begin
                period_q[ch_idx] <= p_next_p0;
                amp_q[ch_idx]    <= a_next_p0;
                ctrl_q[ch_idx]   <= ctrl_next_p0;
                ch_idx           <= last_ch_p0 ? 4'd0 : ch_idx + 4'd1;
                if (last_ch_p0) begin
                    frame_cnt <= frame_cnt + FC_ONE;
                end
                out_channel_p1 <= ch_idx;
                out_period_p1  <= (wr_period && wr_hit) ? wr_period_val : p_next_p0;
                out_amp_p1     <= (wr_amp && wr_hit) ? wr_amp_val : a_next_p0;
                vld_p1         <= 1'b1;
                frame_tick_p1  <= last_ch_p0;
            end else begin
                vld_p1        <= 1'b0;
                frame_tick_p1 <= 1'b0;
            end
            if (wr_period) begin
                period_q[wr_ch] <= wr_period_val;
            end
            if (wr_amp) begin
                amp_q[wr_ch] <= wr_amp_val;
            end
            if (wr_sweep) begin
                ctrl_q[wr_ch] <= decode_ctrl(bus.reg_wdata);
            end
        end
    end

    assign bus.out_channel = out_channel_p1;
    assign bus.out_period  = out_period_p1;
    assign bus.out_amp     = out_amp_p1;
    assign bus.out_valid   = vld_p1;
    assign bus.frame_tick  = frame_tick_p1;

endmodule

// File: tb/tb_pwls_sweep_unit.sv
// Directed bench for pwls_sweep_unit with hand-computed expectations.
module tb_pwls_sweep_unit;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    pwls_sweep_if #(.PERIOD_BITS(13), .AMP_BITS(6), .REG_BITS(16)) bus ();

    pwls_sweep_unit #(
        .NUM_CHANNELS (4),
        .PERIOD_BITS  (13),
        .AMP_BITS     (6),
        .RATE_BITS    (4),
        .REG_BITS     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.en        = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_waddr = '0;
        bus.reg_wdata = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        bus.en        = 1'b0;
        bus.reg_waddr = a;
        bus.reg_wdata = d;
        bus.reg_we    = 1'b1;
        step();
        bus.reg_we    = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] ch;
        do_reset();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_channel !== 4'd0 || bus.out_period !== 13'd0 ||
            bus.out_amp !== 6'd0 || bus.frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b ch=%0d per=%0d amp=%0d tick=%0b, want all 0",
                     bus.out_valid, bus.out_channel, bus.out_period, bus.out_amp, bus.frame_tick);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            ch = 4'(i % 4);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_channel !== ch || bus.out_period !== 13'd0 ||
                bus.out_amp !== 6'd0 || bus.frame_tick !== (ch == 4'd3)) begin
                n_fail++;
                $display("FAIL sched[%0d]: valid=%0b ch=%0d per=%0d amp=%0d tick=%0b, want 1/%0d/0/0/%0b",
                         i, bus.out_valid, bus.out_channel, bus.out_period, bus.out_amp,
                         bus.frame_tick, ch, (ch == 4'd3));
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_period_up();
        logic [12:0] exp_p;
        do_reset();
        wr(6'd4, 16'd100);
        wr(6'd6, 16'h0001);
        bus.en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i % 4 == 1) begin
                exp_p = 13'(101 + i / 4);
                n_tests++;
                if (bus.out_channel !== 4'd1 || bus.out_period !== exp_p) begin
                    n_fail++;
                    $display("FAIL period_up[%0d]: ch=%0d per=%0d, want ch1 per=%0d",
                             i / 4, bus.out_channel, bus.out_period, exp_p);
                end
            end else if (i % 4 == 0) begin
                n_tests++;
                if (bus.out_period !== 13'd0) begin
                    n_fail++;
                    $display("FAIL period_up_ch0[%0d]: per=%0d, want 0", i / 4, bus.out_period);
                end
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_period_down();
        logic [12:0] exp_sat  [3];
        logic [12:0] exp_wrap [3];
        exp_sat[0]  = 13'd0;    exp_sat[1]  = 13'd0;    exp_sat[2]  = 13'd0;
        exp_wrap[0] = 13'd0;    exp_wrap[1] = 13'd8191; exp_wrap[2] = 13'd8190;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            wr(6'd8, 16'd1);
            wr(6'd10, (pass == 0) ? 16'h0011 : 16'h0031);
            bus.en = 1'b1;
            for (int i = 0; i < 12; i++) begin
                step();
                if (i % 4 == 2) begin
                    n_tests++;
                    if (bus.out_period !== ((pass == 0) ? exp_sat[i / 4] : exp_wrap[i / 4])) begin
                        n_fail++;
                        $display("FAIL period_down_%s[%0d]: per=%0d, want %0d",
                                 (pass == 0) ? "sat" : "wrap", i / 4, bus.out_period,
                                 (pass == 0) ? exp_sat[i / 4] : exp_wrap[i / 4]);
                    end
                end
            end
            bus.en = 1'b0;
        end
    endtask

    task automatic test_amp_pingpong();
        logic [5:0] exp_pp  [4];
        logic [5:0] exp_sat [4];
        exp_pp[0]  = 6'd63; exp_pp[1]  = 6'd63; exp_pp[2]  = 6'd62; exp_pp[3]  = 6'd61;
        exp_sat[0] = 6'd63; exp_sat[1] = 6'd63; exp_sat[2] = 6'd63; exp_sat[3] = 6'd63;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            wr(6'd13, 16'd62);
            wr(6'd14, (pass == 0) ? 16'h2100 : 16'h0100);
            bus.en = 1'b1;
            for (int i = 0; i < 16; i++) begin
                step();
                if (i % 4 == 3) begin
                    n_tests++;
                    if (bus.out_amp !== ((pass == 0) ? exp_pp[i / 4] : exp_sat[i / 4])) begin
                        n_fail++;
                        $display("FAIL amp_%s[%0d]: amp=%0d, want %0d",
                                 (pass == 0) ? "pingpong" : "sat", i / 4, bus.out_amp,
                                 (pass == 0) ? exp_pp[i / 4] : exp_sat[i / 4]);
                    end
                end
            end
            bus.en = 1'b0;
        end
    endtask

    task automatic test_rate_en_toggle();
        logic [12:0] exp_r3 [8];
        for (int f = 0; f < 8; f++) exp_r3[f] = (f < 4) ? 13'd1 : 13'd2;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            wr(6'd2, 16'h0003);
            for (int k = 0; k < 32; k++) begin
                bus.en = 1'b1;
                step();
                if (k % 4 == 0) begin
                    n_tests++;
                    if (bus.out_valid !== 1'b1 || bus.out_channel !== 4'd0 ||
                        bus.out_period !== exp_r3[k / 4]) begin
                        n_fail++;
                        $display("FAIL rate3_%s[%0d]: valid=%0b ch=%0d per=%0d, want 1/0/%0d",
                                 (pass == 0) ? "full" : "half", k / 4, bus.out_valid,
                                 bus.out_channel, bus.out_period, exp_r3[k / 4]);
                    end
                end
                if (pass == 1) begin
                    bus.en = 1'b0;
                    step();
                    n_tests++;
                    if (bus.out_valid !== 1'b0 || bus.frame_tick !== 1'b0) begin
                        n_fail++;
                        $display("FAIL en_low[%0d]: valid=%0b tick=%0b, want 0/0",
                                 k, bus.out_valid, bus.frame_tick);
                    end
                end
            end
            bus.en = 1'b0;
        end
    endtask

    task automatic test_write_collision();
        do_reset();
        wr(6'd4, 16'd10);
        wr(6'd5, 16'd5);
        wr(6'd6, 16'h0101);
        bus.en = 1'b1;
        step();
        bus.reg_waddr = 6'd4;
        bus.reg_wdata = 16'd500;
        bus.reg_we    = 1'b1;
        step();
        bus.reg_we    = 1'b0;
        n_tests++;
        if (bus.out_channel !== 4'd1 || bus.out_period !== 13'd500 || bus.out_amp !== 6'd6) begin
            n_fail++;
            $display("FAIL collide_write: ch=%0d per=%0d amp=%0d, want 1/500/6",
                     bus.out_channel, bus.out_period, bus.out_amp);
        end
        for (int i = 0; i < 4; i++) step();
        n_tests++;
        if (bus.out_channel !== 4'd1 || bus.out_period !== 13'd501 || bus.out_amp !== 6'd7) begin
            n_fail++;
            $display("FAIL collide_next: ch=%0d per=%0d amp=%0d, want 1/501/7",
                     bus.out_channel, bus.out_period, bus.out_amp);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_bad_writes();
        logic [12:0] exp_p [4];
        exp_p[0] = 13'd0; exp_p[1] = 13'd0; exp_p[2] = 13'd8191; exp_p[3] = 13'd0;
        do_reset();
        wr(6'd28, 16'd123);
        wr(6'd3, 16'hFFFF);
        wr(6'd8, 16'hFFFF);
        wr(6'd1, 16'h00FF);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (bus.out_period !== exp_p[i]) begin
                n_fail++;
                $display("FAIL bad_write_per[ch%0d]: per=%0d, want %0d", i, bus.out_period, exp_p[i]);
            end
            if (i == 0) begin
                n_tests++;
                if (bus.out_amp !== 6'd63) begin
                    n_fail++;
                    $display("FAIL amp_trunc: amp=%0d, want 63", bus.out_amp);
                end
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        wr(6'd0, 16'd77);
        bus.en = 1'b1;
        step();
        n_tests++;
        if (bus.out_period !== 13'd77) begin
            n_fail++;
            $display("FAIL pre_reset_per: per=%0d, want 77", bus.out_period);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_channel !== 4'd0 || bus.out_period !== 13'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: valid=%0b ch=%0d per=%0d, want 0/0/0",
                     bus.out_valid, bus.out_channel, bus.out_period);
        end
        step();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_channel !== 4'd0 || bus.out_period !== 13'd0) begin
            n_fail++;
            $display("FAIL after_reset: valid=%0b ch=%0d per=%0d, want 1/0/0",
                     bus.out_valid, bus.out_channel, bus.out_period);
        end
        for (int i = 0; i < 3; i++) step();
        n_tests++;
        if (bus.out_channel !== 4'd3 || bus.frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_tick: ch=%0d tick=%0b, want 3/1", bus.out_channel, bus.frame_tick);
        end
        bus.en = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.en        = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_waddr = '0;
        bus.reg_wdata = '0;
        test_reset();
        test_period_up();
        test_period_down();
        test_amp_pingpong();
        test_rate_en_toggle();
        test_write_collision();
        test_bad_writes();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwls_sweep_unit.md
Name: pwls_sweep_unit

Overview:
- Time-multiplexed sweep engine for the PWL synth; successor to the fixed 4-channel sweep registers.
- Serves NUM_CHANNELS channels, one per enabled cycle.
- For each channel it holds a period and an amplitude, and steps them at a programmable exponential rate.
- Adds wrap/saturate period modes and ping-pong amplitude mode.
- Feeds the ALU unit one channel's current period/amp per cycle; the register write port is shared with the synth register map.

Parameters:
- NUM_CHANNELS, 4, channels served (1..16).
- PERIOD_BITS, 13, width of the period value.
- AMP_BITS, 6, width of the amplitude value.
- RATE_BITS, 4, width of each sweep-rate field (1..6).
- REG_BITS, 16, register write data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; when low, all state and outputs hold.
- reg_waddr  in  6  {channel[5:2], reg[1:0]}; reg 0=period, 1=amp, 2=sweep ctrl, 3=reserved.
- reg_wdata  in  REG_BITS  write data, LSB-aligned.
- reg_we  in  1  write strobe; honoured regardless of en.
- out_channel  out  4  channel reported this cycle.
- out_period  out  PERIOD_BITS  that channel's post-update period.
- out_amp  out  AMP_BITS  that channel's post-update amp.
- out_valid  out  1  out_* valid.
- frame_tick  out  1  one-cycle pulse when the channel index wraps.

Behaviour:
Reset (synchronous, active-high):
- All periods, amps and ctrl registers go to 0.
- ch_idx=0, frame_cnt=0.
- All outputs go to 0; out_valid=0.

Scheduling:
- On each cycle with en=1, channel ch_idx is processed.
- ch_idx increments, wrapping at NUM_CHANNELS-1 to 0.
- On the wrap cycle: frame_cnt increments (modulo 2^(2^RATE_BITS-2)) and frame_tick=1 on the next cycle.

Latency:
- Channel processed in cycle N appears on out_* with out_valid=1 in cycle N+1.
- With en=0: out_valid=0 in the next cycle and all other state holds.

Sweep ctrl register layout:
- [RATE_BITS-1:0] prate.
- [RATE_BITS] pdir (1=down).
- [RATE_BITS+1] pwrap.
- [8+RATE_BITS-1:8] arate.
- [8+RATE_BITS] adir (1=down).
- [8+RATE_BITS+1] apingpong.
- Remaining bits are ignored on write and read back as 0.

Step condition (rate r):
- Step if r!=0 and frame_cnt[r-2:0]==0. For r=1 the mask is empty, so it steps every frame.
- This gives one step per 2^(r-1) frames. r=0 means no step.

Period step (±1):
- pwrap=1: modulo 2^PERIOD_BITS.
- pwrap=0: saturate at 0 and at 2^PERIOD_BITS-1.

Amp step (±1):
- apingpong=0: saturate at 0 and at 2^AMP_BITS-1.
- apingpong=1: at a bound where the step would cross, the value is held and the stored adir bit is toggled; the next step moves the other way.

Register writes:
- A write to a channel index >= NUM_CHANNELS, or to reg 3, is ignored.
- A write is truncated to the field width.
- If a write targets the channel being processed in the same cycle, the write wins for the written register, and that register's sweep result is discarded.
- out_* reflects the written value when the write targets period or amp.
- Unwritten registers of that channel still update.

Reset mid-frame: ch_idx and frame_cnt restart from 0; no stale out_valid appears.

Decomposition:
- Package pwls_sweep_pkg holds:
  - register index constants: REG_PERIOD, REG_AMP, REG_SWEEP.
  - ctrl field offsets: P_OFS=0, A_OFS=8.
  - a sweep_ctrl_t struct.
  - a function frame_cnt_bits(RATE_BITS)=2^RATE_BITS-2.
- One sub-module pwls_sweep_step: combinational value/dir/rate/mode/frame_cnt -> next value and next dir. It is instantiated twice, once for period and once for amp, with the width as a parameter.

Test Plan:
- Reset, then en=1 for 8 cycles -> out_channel sequence 0,1,2,3,0,1,2,3; all periods/amps 0; out_valid=1 from cycle 2; frame_tick pulses every 4 cycles.
- ch1 period=100, ctrl prate=1, pdir=0 -> ch1 out_period 101, 102, 103 on successive frames; ch0 stays 0.
- ch2 period=1, prate=1, pdir=1, pwrap=0 -> 0, 0, 0; repeat with pwrap=1 -> 0, 8191, 8190.
- ch3 amp=62, arate=1, adir=0, apingpong=1 -> 63, 63 (adir flips), 62, 61; same with apingpong=0 -> 63, 63, 63.
- ch0 prate=3 -> period steps only on frames where frame_cnt[1:0]==0 (1 step per 4 frames); en toggled 0/1 every cycle -> identical value sequence with half throughput, no out_valid while en=0.
- Write ch1 period=500 in the exact cycle ch1 is processed with prate=1 -> next out_period=500, not 501. Write with addr channel 7 -> no state change. Reset asserted mid-frame -> next cycle all state 0, out_channel restarts at 0.
